// File: rtl/ascon_ps.sv
// ASCON substitution layer p_S: the 5-bit S-box is applied to each of the 64 bit-columns
// of the 320-bit state, and the result is captured in a register when en_i is high.
module ascon_ps (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             en_i,
   input  logic [0:4][63:0] ps_i,
   output logic [0:4][63:0] ps_o,
   output logic             valid_o
);

   function automatic logic [4:0] sbox(input logic [4:0] idx);
      logic [4:0] res;
      case (idx)
         5'h00: res = 5'h04;  5'h01: res = 5'h0b;  5'h02: res = 5'h1f;  5'h03: res = 5'h14;
         5'h04: res = 5'h1a;  5'h05: res = 5'h15;  5'h06: res = 5'h09;  5'h07: res = 5'h02;
         5'h08: res = 5'h1b;  5'h09: res = 5'h05;  5'h0a: res = 5'h08;  5'h0b: res = 5'h12;
         5'h0c: res = 5'h1d;  5'h0d: res = 5'h03;  5'h0e: res = 5'h06;  5'h0f: res = 5'h1c;
         5'h10: res = 5'h1e;  5'h11: res = 5'h13;  5'h12: res = 5'h07;  5'h13: res = 5'h0e;
         5'h14: res = 5'h00;  5'h15: res = 5'h0d;  5'h16: res = 5'h11;  5'h17: res = 5'h18;
         5'h18: res = 5'h10;  5'h19: res = 5'h0c;  5'h1a: res = 5'h01;  5'h1b: res = 5'h19;
         5'h1c: res = 5'h16;  5'h1d: res = 5'h0a;  5'h1e: res = 5'h0f;  default: res = 5'h17;
      endcase
      return res;
   endfunction

   logic [4:0]       w_col [0:63];
   logic [0:4][63:0] w_sub;
   logic [0:4][63:0] r_ps;
   logic             r_valid;

   // Column index takes x0 as its MSB, x4 as its LSB.
   generate
      for (genvar gi = 0; gi < 64; gi++) begin : g_col
         assign w_col[gi] = sbox({ps_i[0][gi], ps_i[1][gi], ps_i[2][gi], ps_i[3][gi], ps_i[4][gi]});
      end
   endgenerate

   always_comb begin
      w_sub = '0;
      for (int j = 0; j < 64; j++) begin
         for (int w = 0; w < 5; w++) begin
            w_sub[w][j] = w_col[j][4-w];
         end
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_ps    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= en_i;
         if (en_i) begin
            r_ps <= w_sub;
         end
      end
   end

   assign ps_o    = r_ps;
   assign valid_o = r_valid;

endmodule

// File: tb/tb_ascon_ps.sv
// Directed bench for ascon_ps: expected states are queued when stimulus is driven and
// popped for comparison one cycle later, using a bitsliced p_S model and the S-box table.
module tb_ascon_ps;

   typedef logic [0:4][63:0] state_t;
   typedef struct {
      string  tag;
      state_t st;
      logic   v;
   } exp_t;

   logic   clock_i = 1'b0;
   logic   resetb_i;
   logic   en_i;
   state_t ps_i;
   state_t ps_o;
   logic   valid_o;

   int     checks = 0;
   int     errors = 0;
   exp_t   sb[$];
   logic [4:0] sbox_t [0:31];

   ascon_ps dut (
      .clock_i (clock_i),
      .resetb_i(resetb_i),
      .en_i    (en_i),
      .ps_i    (ps_i),
      .ps_o    (ps_o),
      .valid_o (valid_o)
   );

   always #5 clock_i = ~clock_i;

   // Reference ASCON bitsliced S-box layer.
   function automatic state_t model(input state_t s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      state_t r;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = x0 ^ (~x1 & x2);
      t1 = x1 ^ (~x2 & x3);
      t2 = x2 ^ (~x3 & x4);
      t3 = x3 ^ (~x4 & x0);
      t4 = x4 ^ (~x0 & x1);
      t1 ^= t0; t0 ^= t4; t3 ^= t2; t2 = ~t2;
      r[0] = t0; r[1] = t1; r[2] = t2; r[3] = t3; r[4] = t4;
      return r;
   endfunction

   function automatic state_t rand_state();
      state_t s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
      return s;
   endfunction

   task automatic chk(input string tag, input state_t exp, input logic ev);
      checks++;
      assert (ps_o === exp) else begin
         errors++;
         $error("FAIL %s ps_o: got %h want %h", tag, ps_o, exp);
      end
      checks++;
      assert (valid_o === ev) else begin
         errors++;
         $error("FAIL %s valid_o: got %b want %b", tag, valid_o, ev);
      end
      $display("txn %s ps_o=%h valid_o=%b", tag, ps_o, valid_o);
   endtask

   task automatic step(input string tag, input state_t st, input logic en,
                       input state_t exp, input logic ev);
      exp_t e;
      exp_t got;
      @(negedge clock_i);
      ps_i = st;
      en_i = en;
      e.tag = tag; e.st = exp; e.v = ev;
      sb.push_back(e);
      @(posedge clock_i);
      #1;
      got = sb.pop_front();
      chk(got.tag, got.st, got.v);
   endtask

   task automatic chk_col(input string tag, input int j, input logic [4:0] exp);
      logic [4:0] col;
      col = {ps_o[0][j], ps_o[1][j], ps_o[2][j], ps_o[3][j], ps_o[4][j]};
      checks++;
      assert (col === exp) else begin
         errors++;
         $error("FAIL %s column %0d: got %h want %h", tag, j, col, exp);
      end
   endtask

   initial begin
      state_t a, b, s, e;
      logic [4:0] cv;
      sbox_t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

      // Asynchronous reset before any clock edge has occurred.
      resetb_i = 1'b0;
      en_i     = 1'b1;
      ps_i     = rand_state();
      #2;
      chk("reset_async", '0, 1'b0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      en_i     = 1'b0;

      step("all_zero", '0, 1'b1, {64'h0, 64'h0, {64{1'b1}}, 64'h0, 64'h0}, 1'b1);
      s = {5{64'hFFFFFFFFFFFFFFFF}};
      step("all_ones", s, 1'b1,
           {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
            64'hFFFFFFFFFFFFFFFF}, 1'b1);

      s = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0eff,
           64'h0011223344556677, 64'h8899aabbccddeeff};
      step("vector", s, 1'b1, model(s), 1'b1);
      chk_col("vector_c63", 63, 5'h13);
      chk_col("vector_c0", 0, 5'h1c);

      // Exhaustive table: index in columns 0, 31, 63; all others see index 0.
      for (int idx = 0; idx < 32; idx++) begin
         s = '0;
         e = '0;
         for (int j = 0; j < 64; j++) begin
            if (j == 0 || j == 31 || j == 63) begin
               for (int w = 0; w < 5; w++) s[w][j] = idx[4-w];
               cv = sbox_t[idx];
            end else begin
               cv = sbox_t[0];
            end
            for (int w = 0; w < 5; w++) e[w][j] = cv[4-w];
         end
         step($sformatf("sbox_%0d", idx), s, 1'b1, e, 1'b1);
      end

      // Back-to-back random captures.
      for (int k = 0; k < 8; k++) begin
         s = rand_state();
         step($sformatf("b2b_%0d", k), s, 1'b1, model(s), 1'b1);
      end

      // Enable low holds the last result while ps_i changes.
      a = rand_state();
      b = rand_state();
      step("hold_capA", a, 1'b1, model(a), 1'b1);
      for (int k = 0; k < 3; k++) step($sformatf("hold_%0d", k), b, 1'b0, model(a), 1'b0);
      step("hold_capB", b, 1'b1, model(b), 1'b1);

      // Reset asserted mid-stream discards the pending capture.
      @(negedge clock_i);
      ps_i = rand_state();
      en_i = 1'b1;
      #2;
      resetb_i = 1'b0;
      #1;
      chk("reset_mid_async", '0, 1'b0);
      @(posedge clock_i);
      #1;
      chk("reset_mid_held", '0, 1'b0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      en_i     = 1'b0;
      @(posedge clock_i);
      #1;
      chk("reset_release_idle", '0, 1'b0);

      s = rand_state();
      step("first_after_reset", s, 1'b1, model(s), 1'b1);
      step("drop_en", rand_state(), 1'b0, model(s), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: bench did not finish within time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
